// File: rtl/bg_sched_pkg.sv
// Shared definitions for the background frame scheduler.
// Register map, CTRL bit positions, FSM state encoding, scroll wrap defaults
// and a wrap-corrected scroll adder.
package bg_sched_pkg;

    localparam int unsigned RegAddrW  = 3;
    localparam int unsigned RegDataW  = 16;
    localparam int unsigned LayerIdxW = 2;

    localparam logic [RegAddrW-1:0] AddrCtrl   = 3'd0;
    localparam logic [RegAddrW-1:0] AddrDwell  = 3'd1;
    localparam logic [RegAddrW-1:0] AddrSpeed  = 3'd2;
    localparam logic [RegAddrW-1:0] AddrSetX   = 3'd3;
    localparam logic [RegAddrW-1:0] AddrSetY   = 3'd4;
    localparam logic [RegAddrW-1:0] AddrStatus = 3'd5;

    localparam int unsigned CtrlRunBit    = 0;
    localparam int unsigned CtrlMaskLsb   = 1;
    localparam int unsigned CtrlAutoBit   = 4;
    localparam int unsigned CtrlIrqClrBit = 5;

    localparam int unsigned HWrapDefault = 1024;
    localparam int unsigned VWrapDefault = 768;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVs,
        StCommit
    } sched_state_e;

    // pos + sign-extended delta, folded back into 0..wrap-1 with one correction.
    function automatic logic [9:0] wrap_add(input logic [9:0] pos, input logic [3:0] delta,
                                            input int unsigned wrap);
        logic signed [11:0] sum;
        logic signed [11:0] lim;
        lim = $signed(12'(wrap));
        sum = $signed({2'b00, pos}) + $signed({{8{delta[3]}}, delta});
        if (sum < 12'sd0) begin
            sum = sum + lim;
        end else if (sum >= lim) begin
            sum = sum - lim;
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/bg_frame_scheduler_if.sv
// Register bus between the TinyQV register interface and the scheduler.
// master: drives reg_addr, reg_wdata, reg_we; receives reg_rdata.
// slave:  receives reg_addr, reg_wdata, reg_we; returns combinational reg_rdata.
interface bg_frame_scheduler_if;
    import bg_sched_pkg::*;

    logic [RegAddrW-1:0] reg_addr;
    logic [RegDataW-1:0] reg_wdata;
    logic                reg_we;
    logic [RegDataW-1:0] reg_rdata;

    modport master (output reg_addr, output reg_wdata, output reg_we, input reg_rdata);
    modport slave  (input reg_addr, input reg_wdata, input reg_we, output reg_rdata);
endinterface

// File: rtl/bg_next_layer.sv
// Finds the next set mask bit strictly above cur, wrapping at NUM_LAYERS.
// mask: layer enable mask; cur: current index; nxt: next set index (cur if none);
// any_set: mask has at least one bit set.
module bg_next_layer
    import bg_sched_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3
) (
    input  logic [NUM_LAYERS-1:0] mask,
    input  logic [LayerIdxW-1:0]  cur,
    output logic [LayerIdxW-1:0]  nxt,
    output logic                  any_set
);
    logic [3:0]           mask_pad;
    logic [LayerIdxW-1:0] cand;
    logic                 found;

    assign mask_pad = 4'(mask);
    assign any_set  = |mask;

    always_comb begin
        nxt   = cur;
        cand  = '0;
        found = 1'b0;
        // k = NUM_LAYERS wraps back onto cur itself, so a lone set bit is still found.
        for (int unsigned k = 1; k <= NUM_LAYERS; k++) begin
            cand = LayerIdxW'((32'(cur) + k) % NUM_LAYERS);
            if (!found && mask_pad[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bg_frame_scheduler.sv
// Per-frame sequencer for the background layers.
// clk/rst: system clock, async active-high reset. bus: register slave port.
// vsync: positive vsync; commits happen one cycle after its rising edge is seen.
// layer_idx/layer_valid: active layer; scroll_x/scroll_y: wrapped offsets;
// frame_irq: sticky dwell expiry; conflict_irq: sticky illegal manual mask.
module bg_frame_scheduler
    import bg_sched_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned H_WRAP     = HWrapDefault,
    parameter int unsigned V_WRAP     = VWrapDefault,
    parameter int unsigned DWELL_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    bg_frame_scheduler_if.slave        bus,
    input  logic                       vsync,
    output logic [LayerIdxW-1:0]       layer_idx,
    output logic                       layer_valid,
    output logic [9:0]                 scroll_x,
    output logic [9:0]                 scroll_y,
    output logic                       frame_irq,
    output logic                       conflict_irq
);
    localparam int unsigned CtrlW = 5;

    logic [CtrlW-1:0]     ctrl_q;
    logic [DWELL_W-1:0]   dwell_q, dwell_cnt_q, eff_dwell;
    logic [7:0]           speed_q, frame_cnt_q;
    logic [9:0]           set_x_q, set_y_q, sx_q, sy_q;
    logic                 pend_x_q, pend_y_q, vs_q;
    logic [LayerIdxW-1:0] idx_q, idx_d, auto_nxt, low_idx;
    logic                 valid_q, valid_d, fi_q, ci_q, conflict_set;
    sched_state_e         state_q;

    logic [NUM_LAYERS-1:0] mask;
    logic [3:0]            mask_pad;
    logic                  run, auto_rot, any_set, low_any, onehot, expire, vs_rise;
    logic                  wr_ctrl, irq_clr;
    logic                  unused_wdata;

    assign run      = ctrl_q[CtrlRunBit];
    assign auto_rot = ctrl_q[CtrlAutoBit];
    assign mask     = ctrl_q[CtrlMaskLsb +: NUM_LAYERS];
    assign mask_pad = 4'(mask);
    assign onehot   = low_any && ((mask & (mask - NUM_LAYERS'(1))) == '0);
    assign vs_rise  = vsync & ~vs_q;
    assign wr_ctrl  = bus.reg_we && (bus.reg_addr == AddrCtrl);
    assign irq_clr  = wr_ctrl && bus.reg_wdata[CtrlIrqClrBit];
    assign eff_dwell = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    // dwell_cnt_q == 0 means "not yet primed since run started", never an expiry.
    assign expire   = (dwell_cnt_q == DWELL_W'(1));
    assign unused_wdata = ^bus.reg_wdata[RegDataW-1:10];

    bg_next_layer #(.NUM_LAYERS(NUM_LAYERS)) u_next_auto (
        .mask    (mask),
        .cur     (idx_q),
        .nxt     (auto_nxt),
        .any_set (any_set)
    );

    // Starting from the top index, the search lands on the lowest set bit.
    bg_next_layer #(.NUM_LAYERS(NUM_LAYERS)) u_next_low (
        .mask    (mask),
        .cur     (LayerIdxW'(NUM_LAYERS - 1)),
        .nxt     (low_idx),
        .any_set (low_any)
    );

    always_comb begin
        idx_d        = idx_q;
        valid_d      = 1'b0;
        conflict_set = 1'b0;
        if (any_set) begin
            if (!auto_rot) begin
                if (onehot) begin
                    idx_d   = low_idx;
                    valid_d = 1'b1;
                end else begin
                    conflict_set = 1'b1;
                end
            end else begin
                valid_d = 1'b1;
                if (expire || !mask_pad[idx_q]) begin
                    idx_d = auto_nxt;
                end
            end
        end
    end

    // Register file; pending scroll flags clear on commit unless re-written that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            dwell_q  <= '0;
            speed_q  <= '0;
            set_x_q  <= '0;
            set_y_q  <= '0;
            pend_x_q <= 1'b0;
            pend_y_q <= 1'b0;
        end else begin
            if (state_q == StCommit) begin
                pend_x_q <= 1'b0;
                pend_y_q <= 1'b0;
            end
            if (bus.reg_we) begin
                case (bus.reg_addr)
                    AddrCtrl:  ctrl_q  <= bus.reg_wdata[CtrlW-1:0];
                    AddrDwell: dwell_q <= bus.reg_wdata[DWELL_W-1:0];
                    AddrSpeed: speed_q <= bus.reg_wdata[7:0];
                    AddrSetX: begin
                        set_x_q  <= wrap_add(bus.reg_wdata[9:0], 4'd0, H_WRAP);
                        pend_x_q <= 1'b1;
                    end
                    AddrSetY: begin
                        set_y_q  <= wrap_add(bus.reg_wdata[9:0], 4'd0, V_WRAP);
                        pend_y_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            vs_q        <= 1'b0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            sx_q        <= '0;
            sy_q        <= '0;
            fi_q        <= 1'b0;
            ci_q        <= 1'b0;
            dwell_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            vs_q <= vsync;
            if (irq_clr) begin
                fi_q <= 1'b0;
                ci_q <= 1'b0;
            end
            case (state_q)
                StIdle:   if (run) state_q <= StWaitVs;
                StWaitVs: if (vs_rise) state_q <= StCommit;
                StCommit: begin
                    state_q     <= StWaitVs;
                    sx_q        <= pend_x_q ? set_x_q : wrap_add(sx_q, speed_q[3:0], H_WRAP);
                    sy_q        <= pend_y_q ? set_y_q : wrap_add(sy_q, speed_q[7:4], V_WRAP);
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                    idx_q       <= idx_d;
                    valid_q     <= valid_d;
                    if (conflict_set) ci_q <= 1'b1;
                    if (dwell_cnt_q == '0) begin
                        dwell_cnt_q <= eff_dwell;
                    end else if (expire) begin
                        dwell_cnt_q <= eff_dwell;
                        fi_q        <= 1'b1;
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (!run) begin
                state_q     <= StIdle;
                valid_q     <= 1'b0;
                dwell_cnt_q <= '0;
            end
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            AddrCtrl:   bus.reg_rdata[CtrlW-1:0]   = ctrl_q;
            AddrDwell:  bus.reg_rdata[DWELL_W-1:0] = dwell_q;
            AddrSpeed:  bus.reg_rdata[7:0]         = speed_q;
            AddrSetX:   bus.reg_rdata[9:0]         = set_x_q;
            AddrSetY:   bus.reg_rdata[9:0]         = set_y_q;
            AddrStatus: bus.reg_rdata = {frame_cnt_q, 3'b000, ci_q, fi_q, valid_q, idx_q};
            default: ;
        endcase
    end

    assign layer_idx    = idx_q;
    assign layer_valid  = valid_q;
    assign scroll_x     = sx_q;
    assign scroll_y     = sy_q;
    assign frame_irq    = fi_q;
    assign conflict_irq = ci_q;
endmodule

// File: tb/tb_bg_frame_scheduler.sv
module tb_bg_frame_scheduler;
    import bg_sched_pkg::*;

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic [9:0] x;
        logic [9:0] y;
        logic       fi;
        logic       ci;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic [1:0] layer_idx;
    logic       layer_valid, frame_irq, conflict_irq;
    logic [9:0] scroll_x, scroll_y;

    int   checks = 0;
    int   errors = 0;
    int   frame_no = 0;
    exp_t exp_q[$];

    bg_frame_scheduler_if bus ();

    bg_frame_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .vsync        (vsync),
        .layer_idx    (layer_idx),
        .layer_valid  (layer_valid),
        .scroll_x     (scroll_x),
        .scroll_y     (scroll_y),
        .frame_irq    (frame_irq),
        .conflict_irq (conflict_irq)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int idx, input int valid, input int x, input int y,
                                input int fi, input int ci);
        exp_t e;
        e.idx = 2'(idx); e.valid = 1'(valid); e.x = 10'(x); e.y = 10'(y);
        e.fi = 1'(fi); e.ci = 1'(ci);
        return e;
    endfunction

    function automatic exp_t outs();
        return {layer_idx, layer_valid, scroll_x, scroll_y, frame_irq, conflict_irq};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.reg_addr = a; bus.reg_wdata = d; bus.reg_we = 1'b1;
        @(negedge clk);
        bus.reg_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        bus.reg_addr = a;
        #1;
        chk(name, 32'(bus.reg_rdata), 32'(exp));
    endtask

    // One vsync pulse; optionally writes CTRL during the COMMIT cycle.
    task automatic frame(input exp_t e, input bit wr_in_commit, input logic [15:0] d);
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        if (wr_in_commit) begin
            bus.reg_addr = AddrCtrl; bus.reg_wdata = d; bus.reg_we = 1'b1;
        end
        @(negedge clk);
        bus.reg_we = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Outputs are due two rising clock edges after vsync rises at the pin.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge vsync);
            repeat (2) @(posedge clk);
            #1;
            frame_no++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame%0d: no expected entry queued", frame_no);
            end else begin
                e = exp_q.pop_front();
                if (outs() !== e) begin
                    errors++;
                    $display("FAIL frame%0d: got idx=%0d valid=%0d x=%0d y=%0d fi=%0d ci=%0d expected idx=%0d valid=%0d x=%0d y=%0d fi=%0d ci=%0d",
                             frame_no, layer_idx, layer_valid, scroll_x, scroll_y, frame_irq,
                             conflict_irq, e.idx, e.valid, e.x, e.y, e.fi, e.ci);
                end
            end
        end
    end

    initial begin : stim
        bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", 32'(outs()), 32'(0));
        rd_chk("reset_status", AddrStatus, 16'h0000);
        rd_chk("reset_ctrl", AddrCtrl, 16'h0000);

        // Manual mode with two bits set.
        wr(AddrCtrl, 16'h000B);
        rd_chk("ctrl_readback", AddrCtrl, 16'h000B);
        frame(mk(0, 0, 0, 0, 0, 1), 1'b0, 16'h0);

        // Clear irqs, select layer 1; DWELL=0 acts as 1 so every frame expires.
        wr(AddrCtrl, 16'h0025);
        chk("irq_clr_immediate", 32'(conflict_irq), 32'(0));
        rd_chk("irq_clr_reads_0", AddrCtrl, 16'h0005);
        frame(mk(1, 1, 0, 0, 1, 0), 1'b0, 16'h0);

        // Scroll wrap.
        wr(AddrSetX, 16'd1022);
        wr(AddrSetY, 16'd0);
        wr(AddrSpeed, 16'h00F3);
        frame(mk(1, 1, 1022, 0, 1, 0), 1'b0, 16'h0);
        frame(mk(1, 1, 1, 767, 1, 0), 1'b0, 16'h0);
        wr(AddrSetX, 16'd0);
        wr(AddrSetY, 16'd767);
        wr(AddrSpeed, 16'h002F);
        frame(mk(1, 1, 0, 767, 1, 0), 1'b0, 16'h0);
        frame(mk(1, 1, 1023, 1, 1, 0), 1'b0, 16'h0);
        rd_chk("status_6_frames", AddrStatus, 16'h060D);

        // Asynchronous reset between edges while waiting for vsync.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 32'(outs()), 32'(0));
        rd_chk("async_reset_status", AddrStatus, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        frame(mk(0, 0, 0, 0, 0, 0), 1'b0, 16'h0);
        rd_chk("no_commit_without_run", AddrStatus, 16'h0000);

        // Auto-rotate over mask 0b111 with DWELL=2.
        wr(AddrDwell, 16'd2);
        wr(AddrCtrl, 16'h001F);
        frame(mk(0, 1, 0, 0, 0, 0), 1'b0, 16'h0);
        frame(mk(0, 1, 0, 0, 0, 0), 1'b0, 16'h0);
        frame(mk(1, 1, 0, 0, 1, 0), 1'b0, 16'h0);
        wr(AddrCtrl, 16'h003F);
        chk("frame_irq_cleared", 32'(frame_irq), 32'(0));
        frame(mk(1, 1, 0, 0, 0, 0), 1'b0, 16'h0);
        frame(mk(2, 1, 0, 0, 1, 0), 1'b0, 16'h0);
        wr(AddrCtrl, 16'h003F);
        frame(mk(2, 1, 0, 0, 0, 0), 1'b0, 16'h0);
        // irq_clr lands on the same edge as a dwell expiry: set wins.
        frame(mk(0, 1, 0, 0, 1, 0), 1'b1, 16'h003F);

        // Current layer's bit cleared in auto mode.
        wr(AddrCtrl, 16'h001D);
        frame(mk(1, 1, 0, 0, 1, 0), 1'b0, 16'h0);

        // run=0: outputs frozen, layer_valid low, vsync ignored.
        wr(AddrCtrl, 16'h001C);
        frame(mk(1, 0, 0, 0, 1, 0), 1'b0, 16'h0);

        // Empty mask: invalid, index holds.
        wr(AddrCtrl, 16'h0001);
        frame(mk(1, 0, 0, 0, 1, 0), 1'b0, 16'h0);
        rd_chk("status_9_frames", AddrStatus, 16'h0909);

        wr(3'd6, 16'hFFFF);
        rd_chk("unused_addr", 3'd6, 16'h0000);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
